masked_mux_sched: RTL and testbench

// - Sequencer for the 2-share masked select datapath (mux2_gadget): streams LEN word pairs (A[i], B[i]) from
//   a shared operand RAM through the gadget under one masked select bit, writes results to RAM at OUT base.
// - Owns address generation, randomness handshake, fixed-latency valid tracking and job start/done.
// - Sits between the sorting/decode control FSM and the masked arithmetic RAM ports.

---
 rtl/masked_mux_sched_pkg.sv | 27 ++
 rtl/masked_mux_sched_if.sv | 51 +++++
 rtl/masked_mux_sched_mux2_gadget.sv | 66 ++++++
 rtl/masked_mux_sched.sv | 169 ++++++++++++++++
 tb/tb_masked_mux_sched.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/masked_mux_sched_pkg.sv
// ============================================================================
// Module  : masked_mux_sched_pkg
// Brief   : Shared types and constants for the masked select sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package masked_mux_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PIPE_LAT = 3;
    localparam int RND_DLY  = 2;

    // Index of the fresh-randomness word shared by share pair (i, j), i < j.
    function automatic int pair_idx(input int i, input int j, input int d);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/masked_mux_sched_if.sv
// ============================================================================
// Module  : masked_mux_sched_if
// Brief   : Job control, randomness and operand RAM bundle of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface masked_mux_sched_if #(
    parameter int D    = 2,
    parameter int WORD = 13,
    parameter int AW   = 10
);
    localparam int NRND = D * (D - 1) / 2 * WORD;

    logic                start;
    logic [AW:0]         len;
    logic [AW-1:0]       base_a;
    logic [AW-1:0]       base_b;
    logic [AW-1:0]       base_o;
    logic [D-1:0]        s_sel;
    logic                busy;
    logic                done;
    logic                rnd_valid;
    logic                rnd_ready;
    logic [NRND-1:0]     rnd_in;
    logic                rd_en;
    logic [AW-1:0]       rd_addr_a;
    logic [AW-1:0]       rd_addr_b;
    logic [D*WORD-1:0]   rd_data_a;
    logic [D*WORD-1:0]   rd_data_b;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [D*WORD-1:0]   wr_data;

    modport master (
        output start, len, base_a, base_b, base_o, s_sel,
        output rnd_valid, rnd_in, rd_data_a, rd_data_b,
        input  busy, done, rnd_ready, rd_en, rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, len, base_a, base_b, base_o, s_sel,
        input  rnd_valid, rnd_in, rd_data_a, rd_data_b,
        output busy, done, rnd_ready, rd_en, rd_addr_a, rd_addr_b,
        output wr_en, wr_addr, wr_data
    );

endinterface

`default_nettype wire

// File: rtl/masked_mux_sched_mux2_gadget.sv
// ============================================================================
// Module  : mux2_gadget
// Brief   : D-share masked 2:1 select, y = b ^ (s & (a ^ b)), two register stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_gadget
    import masked_mux_sched_pkg::*;
#(
    parameter  int D    = 2,
    parameter  int WORD = 13,
    localparam int NRND = D * (D - 1) / 2 * WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [D*WORD-1:0]   a_i,
    input  logic [D*WORD-1:0]   b_i,
    input  logic [D-1:0]        s_i,
    input  logic [NRND-1:0]     rnd_i,
    output logic [D*WORD-1:0]   y_o
);

    logic [D-1:0][WORD-1:0] d_q;
    logic [D-1:0][WORD-1:0] b1_q;
    logic [D-1:0][WORD-1:0] z_d;
    logic [D-1:0][WORD-1:0] z_q;
    logic [D-1:0][WORD-1:0] b2_q;

    // Share-wise AND with per-pair refresh; each cross term is folded into
    // the randomness before it meets the other cross term.
    always_comb begin
        z_d = '0;
        for (int i = 0; i < D; i++) begin
            z_d[i] = {WORD{s_i[i]}} & d_q[i];
        end
        for (int i = 0; i < D; i++) begin
            for (int j = i + 1; j < D; j++) begin
                z_d[i] = z_d[i] ^ rnd_i[pair_idx(i, j, D) * WORD +: WORD];
                z_d[j] = z_d[j]
                       ^ ((rnd_i[pair_idx(i, j, D) * WORD +: WORD]
                           ^ ({WORD{s_i[i]}} & d_q[j]))
                          ^ ({WORD{s_i[j]}} & d_q[i]));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= '0;
            b1_q <= '0;
            z_q  <= '0;
            b2_q <= '0;
        end else begin
            d_q  <= a_i ^ b_i;
            b1_q <= b_i;
            z_q  <= z_d;
            b2_q <= b1_q;
        end
    end

    assign y_o = b2_q ^ z_q;

endmodule

`default_nettype wire

// File: rtl/masked_mux_sched.sv
// ============================================================================
// Module  : masked_mux_sched
// Brief   : Streams LEN masked word pairs from RAM through mux2_gadget and
//           writes the selected shares back. Optional MASKED_MUX_STALL_CNT_EN
//           adds a saturating count of randomness-starved issue cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module masked_mux_sched
    import masked_mux_sched_pkg::*;
#(
    parameter int D    = 2,
    parameter int WORD = 13,
    parameter int AW   = 10
) (
    input  logic                clk,
    input  logic                rst,
    masked_mux_sched_if.slave   bus
`ifdef MASKED_MUX_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    localparam int NRND = D * (D - 1) / 2 * WORD;

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [AW:0]        len_q;
    logic [AW:0]        cnt_q;
    logic [AW-1:0]      base_a_q;
    logic [AW-1:0]      base_b_q;
    logic [AW-1:0]      base_o_q;
    logic [D-1:0]       s_q;
    logic [PIPE_LAT-1:0] vld_q;
    logic [AW-1:0]      waddr_q [PIPE_LAT];
    logic [NRND-1:0]    rnd_q   [RND_DLY];
    logic               issue;
    logic               last;

    assign issue = (state_q == ST_ISSUE) && bus.rnd_valid;
    assign last  = issue && (cnt_q == len_q - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_o_q <= '0;
            s_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_q    <= bus.len;
                        base_a_q <= bus.base_a;
                        base_b_q <= bus.base_b;
                        base_o_q <= bus.base_o;
                        s_q      <= bus.s_sel;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (bus.len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the word being written now remains.
                    if (vld_q[PIPE_LAT-2:0] == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                waddr_q[k] <= '0;
            end
            for (int k = 0; k < RND_DLY; k++) begin
                rnd_q[k] <= '0;
            end
        end else begin
            vld_q      <= {vld_q[PIPE_LAT-2:0], issue};
            waddr_q[0] <= base_o_q + cnt_q[AW-1:0];
            for (int k = 1; k < PIPE_LAT; k++) begin
                waddr_q[k] <= waddr_q[k-1];
            end
            if (issue) begin
                rnd_q[0] <= bus.rnd_in;
            end
            for (int k = 1; k < RND_DLY; k++) begin
                rnd_q[k] <= rnd_q[k-1];
            end
        end
    end

    mux2_gadget #(
        .D    (D),
        .WORD (WORD)
    ) u_gadget (
        .clk   (clk),
        .rst   (rst),
        .a_i   (bus.rd_data_a),
        .b_i   (bus.rd_data_b),
        .s_i   (s_q),
        .rnd_i (rnd_q[RND_DLY-1]),
        .y_o   (bus.wr_data)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = issue;
    assign bus.rnd_ready = issue;
    assign bus.rd_addr_a = base_a_q + cnt_q[AW-1:0];
    assign bus.rd_addr_b = base_b_q + cnt_q[AW-1:0];
    assign bus.wr_en     = vld_q[PIPE_LAT-1];
    assign bus.wr_addr   = waddr_q[PIPE_LAT-1];

`ifdef MASKED_MUX_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == ST_IDLE && bus.start) begin
            stall_q <= '0;
        end else if (state_q == ST_ISSUE && !bus.rnd_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_masked_mux_sched.sv
// ============================================================================
// Module  : tb_masked_mux_sched
// Brief   : Directed jobs with a write scoreboard for masked_mux_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_masked_mux_sched;

    localparam int D    = 2;
    localparam int WORD = 13;
    localparam int AW   = 10;
    localparam int NRND = D * (D - 1) / 2 * WORD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    masked_mux_sched_if #(.D(D), .WORD(WORD), .AW(AW)) bus ();

`ifdef MASKED_MUX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    masked_mux_sched #(.D(D), .WORD(WORD), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MASKED_MUX_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [WORD-1:0] val;
        int              cyc;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              rd_cyc_q[$];
    logic [D*WORD-1:0] mem [1024];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int rd_total = 0;
    int rdy_total = 0;
    int wr_total = 0;
    int done_total = 0;
    int last_done_cyc = -1;
    bit rnd_tog = 1'b0;
    int c_base = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Operand RAM: one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem[bus.rd_addr_a];
            bus.rd_data_b <= mem[bus.rd_addr_b];
        end
    end

    // Randomness source: always valid, or alternating starting on the first ISSUE cycle.
    initial begin
        bus.rnd_valid = 1'b1;
        bus.rnd_in    = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.rnd_in    = NRND'($urandom);
            bus.rnd_valid = rnd_tog ? (((cyc - c_base) % 2) == 1) : 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (bus.rd_en) begin
            rd_total++;
            rd_cyc_q.push_back(cyc);
        end
        if (bus.rnd_ready) begin
            rdy_total++;
            if (!bus.rnd_valid) chk("rnd_ready_without_valid", 64'(1), 64'(0));
        end
        if (bus.done) begin
            done_total++;
            last_done_cyc = cyc;
        end
        if (bus.wr_en) begin
            wr_total++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(bus.wr_addr), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
                chk("wr_data_unmasked",
                    64'(bus.wr_data[WORD-1:0] ^ bus.wr_data[2*WORD-1:WORD]), 64'(mon_e.val));
                if (mon_e.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic load(input int addr, input logic [WORD-1:0] val);
        logic [WORD-1:0] m;
        m = WORD'($urandom);
        mem[addr] = {val ^ m, m};
    endtask

    task automatic push(input int addr, input logic [WORD-1:0] val, input int c);
        exp_t e;
        e.addr = AW'(addr);
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic start_job(input int l, input int ba, input int bb, input int bo,
                             input logic [D-1:0] s, output int c0);
        @(posedge clk);
        #1;
        c0          = cyc;
        c_base      = cyc;
        bus.start   = 1'b1;
        bus.len     = (AW+1)'(l);
        bus.base_a  = AW'(ba);
        bus.base_b  = AW'(bb);
        bus.base_o  = AW'(bo);
        bus.s_sel   = s;
    endtask

    task automatic release_start;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_job(input int done0, input int exp_done_cyc);
        int k;
        k = 0;
        while (done_total == done0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_pulses", 64'(done_total - done0), 64'(1));
        if (done_total > done0) chk("done_cycle", 64'(last_done_cyc), 64'(exp_done_cyc));
        chk("done_one_cycle", 64'(bus.done), 64'(0));
        chk("busy_after_done", 64'(bus.busy), 64'(0));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int c0, d0, r0, y0, w0;
        logic [WORD-1:0] av [4];
        logic [WORD-1:0] bv [4];

        av = '{13'h0123, 13'h1FFF, 13'h0000, 13'h0AAA};
        bv = '{13'h1555, 13'h0F0F, 13'h1234, 13'h0001};
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            load(i, av[i]);
            load(16 + i, bv[i]);
        end
        load(1023, 13'h1ABC);
        load(500, 13'h0111);
        load(501, 13'h0222);
        load(502, 13'h0333);

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.len    = '0;
        bus.base_a = '0;
        bus.base_b = '0;
        bus.base_o = '0;
        bus.s_sel  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
        chk("rst_rnd_ready", 64'(bus.rnd_ready), 64'(0));
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        rst = 1'b0;

        // Job 1: len 4, s=1 selects A, exact latency
        rd_cyc_q.delete();
        d0 = done_total; r0 = rd_total;
        start_job(4, 0, 16, 32, 2'b10, c0);
        for (int i = 0; i < 4; i++) push(32 + i, av[i], c0 + 4 + i);
        release_start();
        finish_job(d0, c0 + 8);
        chk("job1_rd_count", 64'(rd_total - r0), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < rd_cyc_q.size()) chk("job1_rd_cycle", 64'(rd_cyc_q[i]), 64'(c0 + 1 + i));
        end

        // Job 2: s=0 (shares 11) selects B
        d0 = done_total;
        start_job(4, 0, 16, 48, 2'b11, c0);
        for (int i = 0; i < 4; i++) push(48 + i, bv[i], c0 + 4 + i);
        release_start();
        finish_job(d0, c0 + 8);

        // Job 3: randomness toggling 1,0,1,0 gives write gaps
        rnd_tog = 1'b1;
        d0 = done_total; r0 = rd_total;
        start_job(3, 0, 16, 64, 2'b01, c0);
        for (int i = 0; i < 3; i++) push(64 + i, av[i], c0 + 4 + 2 * i);
        release_start();
        finish_job(d0, c0 + 9);
        chk("job3_rd_count", 64'(rd_total - r0), 64'(3));
`ifdef MASKED_MUX_STALL_CNT_EN
        chk("job3_stall_cnt", 64'(stall_cnt), 64'(2));
`endif
        rnd_tog = 1'b0;

        // Job 4: len 0 -> immediate done, no traffic
        d0 = done_total; r0 = rd_total; y0 = rdy_total; w0 = wr_total;
        start_job(0, 0, 16, 80, 2'b10, c0);
        release_start();
        finish_job(d0, c0 + 1);
        chk("len0_rd_count", 64'(rd_total - r0), 64'(0));
        chk("len0_rdy_count", 64'(rdy_total - y0), 64'(0));
        chk("len0_wr_count", 64'(wr_total - w0), 64'(0));

        // Job 5: address wrap, start and s_sel changes while busy ignored
        d0 = done_total;
        start_job(3, 1023, 500, 1022, 2'b10, c0);
        push(1022, 13'h1ABC, c0 + 4);
        push(1023, av[0], c0 + 5);
        push(0, av[1], c0 + 6);
        release_start();
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.len    = 11'd1;
        bus.base_a = 10'd5;
        bus.base_o = 10'd0;
        bus.s_sel  = 2'b11;
        release_start();
        finish_job(d0, c0 + 7);

        // Job 6: reset in the middle of ISSUE
        d0 = done_total; w0 = wr_total;
        start_job(8, 0, 16, 100, 2'b10, c0);
        release_start();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("midrst_rnd_ready", 64'(bus.rnd_ready), 64'(0));
        chk("midrst_wr_en", 64'(bus.wr_en), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_writes", 64'(wr_total - w0), 64'(0));
        chk("midrst_no_done", 64'(done_total - d0), 64'(0));

        // Job 7: fresh job after reset, s=0 (shares 00) selects B
        d0 = done_total;
        start_job(2, 0, 16, 200, 2'b00, c0);
        push(200, bv[0], c0 + 4);
        push(201, bv[1], c0 + 5);
        release_start();
        finish_job(d0, c0 + 6);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
